// File: rtl/rising_edge_detect.sv
// Per-lane level-to-pulse edge detector with optional input synchronizer.
// Define RISING_EDGE_DETECT_CNT_EN to add the edge_cnt event counter.
module rising_edge_detect #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0,
  parameter bit INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] pe,
  output logic [WIDTH-1:0] ne,
`ifdef RISING_EDGE_DETECT_CNT_EN
  output logic [15:0]      edge_cnt,
`endif
  output logic             any_pe
);

  localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{INIT_LEVEL}};

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sq;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sq[i] <= RST_VAL;
        end else begin
          sq[0] <= sig;
          for (int i = 1; i < SYNC_STAGES; i++)
            sq[i] <= sq[i-1];
        end
      end

      assign s = sq[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= RST_VAL;
    else     prev <= s;
  end

  assign pe     = s & ~prev;
  assign ne     = ~s & prev;
  assign any_pe = |pe;

`ifdef RISING_EDGE_DETECT_CNT_EN
  // One count per cycle with any rising edge, regardless of lane count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         edge_cnt <= 16'd0;
    else if (any_pe) edge_cnt <= edge_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rising_edge_detect.sv
// Self-checking bench for rising_edge_detect: table vectors plus
// hand sequences for reset, synchronizer latency and counter.
module tb_rising_edge_detect;

  logic       clk;
  logic       rst;
  logic       sig_a;
  logic [3:0] sig_w;
  logic       sig_s;

  logic       pe0, ne0, ape0;
  logic       pe1, ne1, ape1;
  logic [3:0] pe4, ne4;
  logic       ape4;
  logic       pe2, ne2, ape2;
`ifdef RISING_EDGE_DETECT_CNT_EN
  logic [15:0] cnt0, cnt1, cnt4, cnt2;
`endif

  int checks;
  int errors;

  rising_edge_detect #(.WIDTH(1), .SYNC_STAGES(0), .INIT_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .sig(sig_a), .pe(pe0), .ne(ne0),
`ifdef RISING_EDGE_DETECT_CNT_EN
    .edge_cnt(cnt0),
`endif
    .any_pe(ape0)
  );

  rising_edge_detect #(.WIDTH(1), .SYNC_STAGES(0), .INIT_LEVEL(1'b1)) u1 (
    .clk(clk), .rst(rst), .sig(sig_a), .pe(pe1), .ne(ne1),
`ifdef RISING_EDGE_DETECT_CNT_EN
    .edge_cnt(cnt1),
`endif
    .any_pe(ape1)
  );

  rising_edge_detect #(.WIDTH(4), .SYNC_STAGES(0), .INIT_LEVEL(1'b0)) u4 (
    .clk(clk), .rst(rst), .sig(sig_w), .pe(pe4), .ne(ne4),
`ifdef RISING_EDGE_DETECT_CNT_EN
    .edge_cnt(cnt4),
`endif
    .any_pe(ape4)
  );

  rising_edge_detect #(.WIDTH(1), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .sig(sig_s), .pe(pe2), .ne(ne2),
`ifdef RISING_EDGE_DETECT_CNT_EN
    .edge_cnt(cnt2),
`endif
    .any_pe(ape2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [3:0] w;
    logic       pe0;
    logic       ne0;
    logic [3:0] pe4;
    logic       any4;
  } vec_t;

  vec_t tbl [11];
  vec_t sb [$];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    sig_a  = 1'b0;
    sig_w  = 4'h0;
    sig_s  = 1'b0;

    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0101, 1'b1};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b1010, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1};
    tbl[6]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};

    // reset applied before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_pe0", 16'(pe0), 16'd0);
    chk("rst_ne0", 16'(ne0), 16'd0);
    chk("rst_pe1", 16'(pe1), 16'd0);
    chk("rst_ne1", 16'(ne1), 16'd1);
    chk("rst_pe4", 16'(pe4), 16'd0);
    chk("rst_pe2", 16'(pe2), 16'd0);

    // sig held high through reset release
    sig_a = 1'b1;
    #1;
    chk("rsthi_pe0", 16'(pe0), 16'd1);
    chk("rsthi_ne0", 16'(ne0), 16'd0);
    chk("rsthi_pe1", 16'(pe1), 16'd0);
    chk("rsthi_ne1", 16'(ne1), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_pe0", 16'(pe0), 16'd1);
    chk("rel_pe1", 16'(pe1), 16'd0);
    @(posedge clk); #1;
    chk("rel1_pe0", 16'(pe0), 16'd0);
    chk("rel1_pe1", 16'(pe1), 16'd0);
    chk("rel1_ne0", 16'(ne0), 16'd0);
    @(posedge clk); #1;
    chk("rel2_pe0", 16'(pe0), 16'd0);
    chk("rel2_pe1", 16'(pe1), 16'd0);
    sig_a = 1'b0;
    #1;
    chk("fall_ne0", 16'(ne0), 16'd1);
    chk("fall_ne1", 16'(ne1), 16'd1);
    chk("fall_pe1", 16'(pe1), 16'd0);

    // table vectors through the scoreboard
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      sig_a = tbl[i].a;
      sig_w = tbl[i].w;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_pe0", i), 16'(pe0), 16'(e.pe0));
      chk($sformatf("v%0d_ne0", i), 16'(ne0), 16'(e.ne0));
      chk($sformatf("v%0d_both", i), 16'(pe0 & ne0), 16'd0);
      chk($sformatf("v%0d_pe4", i), 16'(pe4), 16'(e.pe4));
      chk($sformatf("v%0d_any4", i), 16'(ape4), 16'(e.any4));
    end

    // two-stage synchronizer latency
    @(posedge clk); #1;
    sig_s = 1'b1;
    @(negedge clk);
    chk("sync_k0", 16'(pe2), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sync_k1", 16'(pe2), 16'd0);
    @(posedge clk); #1;
    sig_a = 1'b1;
    @(negedge clk);
    chk("sync_k2", 16'(pe2), 16'd1);
    chk("mid_pe1", 16'(pe1), 16'd1);
    chk("mid_pe0", 16'(pe0), 16'd1);

    // reset mid-pulse, no clock edge in between
    #2 rst = 1'b1;
    #1;
    chk("rmid_pe2", 16'(pe2), 16'd0);
    chk("rmid_ne2", 16'(ne2), 16'd0);
    chk("rmid_pe1", 16'(pe1), 16'd0);
    chk("rmid_ne1", 16'(ne1), 16'd0);
    chk("rmid_pe0", 16'(pe0), 16'd1);

`ifdef RISING_EDGE_DETECT_CNT_EN
    chk("cnt_rst", cnt4, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sig_w = 4'hF;
      @(posedge clk); #1;
      sig_w = 4'h0;
    end
    @(posedge clk); #1;
    chk("cnt4", cnt4, 16'd10);
    chk("cnt0", cnt0, 16'd1);
    chk("cnt1", cnt1, 16'd0);
`else
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_pe0", 16'(pe0), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
